// File: rtl/riscv_ctrl_pkg.sv
// Shared constants for the RV32I multicycle controller: opcodes, FSM state
// encodings and ALU-decoder operation codes.
package riscv_ctrl_pkg;

   localparam logic [6:0] OP_R    = 7'b0110011;
   localparam logic [6:0] OP_I    = 7'b0010011;
   localparam logic [6:0] OP_LUI  = 7'b0110111;
   localparam logic [6:0] OP_LW   = 7'b0000011;
   localparam logic [6:0] OP_SW   = 7'b0100011;
   localparam logic [6:0] OP_BEQ  = 7'b1100011;

   localparam logic [1:0] ALU_ADD = 2'b00;
   localparam logic [1:0] ALU_BR  = 2'b01;
   localparam logic [1:0] ALU_RI  = 2'b10;
   localparam logic [1:0] ALU_LUI = 2'b11;

   // Fixed encodings so state values stay stable for legacy debug tooling.
   localparam logic [3:0] ST_FETCH   = 4'd0;
   localparam logic [3:0] ST_DECODE  = 4'd1;
   localparam logic [3:0] ST_EXECUTE = 4'd2;
   localparam logic [3:0] ST_ALU_WB  = 4'd3;
   localparam logic [3:0] ST_ADDR    = 4'd4;
   localparam logic [3:0] ST_MEM_RD  = 4'd5;
   localparam logic [3:0] ST_MEM_WB  = 4'd6;
   localparam logic [3:0] ST_MEM_WR  = 4'd7;
   localparam logic [3:0] ST_BRANCH  = 4'd8;

   typedef enum logic [3:0] {
      S_FETCH   = ST_FETCH,
      S_DECODE  = ST_DECODE,
      S_EXECUTE = ST_EXECUTE,
      S_ALU_WB  = ST_ALU_WB,
      S_ADDR    = ST_ADDR,
      S_MEM_RD  = ST_MEM_RD,
      S_MEM_WB  = ST_MEM_WB,
      S_MEM_WR  = ST_MEM_WR,
      S_BRANCH  = ST_BRANCH
   } ctrl_state_e;

endpackage

// File: rtl/multicycle_controller_mem_wait_timer.sv
// Counts consecutive not-ready cycles of a memory access and flags expiry
// on the cycle the count reaches MEM_TIMEOUT-1 while still waiting.
module mem_wait_timer #(
   parameter int MEM_TIMEOUT = 16
) (
   input  logic clk,
   input  logic reset_n,
   input  logic clear,
   input  logic count,
   output logic expired
);

   localparam int W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
   localparam logic [W-1:0] LAST = W'((MEM_TIMEOUT > 0) ? MEM_TIMEOUT - 1 : 0);

   logic [W-1:0] cnt_q, cnt_d;

   always_comb begin
      expired = (MEM_TIMEOUT != 0) && count && (cnt_q == LAST);
      cnt_d   = cnt_q;
      // An expired access restarts from zero because FETCH is re-entered.
      if (clear || expired) begin
         cnt_d = '0;
      end else if (count) begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/multicycle_controller.sv
// Multicycle RV32I sequencer: steps each instruction through fetch, decode,
// execute/memory and writeback, driving datapath strobes per state.
module multicycle_controller
   import riscv_ctrl_pkg::*;
#(
   parameter int MEM_TIMEOUT = 16,
   parameter int CNT_W       = 32
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic [6:0]       opcode,
   input  logic             zero,
   input  logic             imem_ready,
   input  logic             dmem_ready,
   output logic             imem_req,
   output logic             dmem_req,
   output logic             dmem_we,
   output logic             ir_write,
   output logic             pc_write,
   output logic             pc_src,
   output logic             alu_src_b,
   output logic [1:0]       alu_op,
   output logic             reg_write,
   output logic             mem_to_reg,
   output logic             illegal_instr,
   output logic             bus_error,
   output logic [CNT_W-1:0] instret
);

   ctrl_state_e      state_q, state_d;
   logic [6:0]       op_q, op_d;
   logic [CNT_W-1:0] instret_q, instret_d;

   logic in_wait;
   logic mem_ready;
   logic wait_cnt;
   logic wait_clr;
   logic expired;

   always_comb begin
      in_wait   = (state_q == S_FETCH) || (state_q == S_MEM_RD) || (state_q == S_MEM_WR);
      mem_ready = (state_q == S_FETCH) ? imem_ready : dmem_ready;
      wait_cnt  = in_wait && !mem_ready;
      wait_clr  = !wait_cnt;
   end

   mem_wait_timer #(
      .MEM_TIMEOUT (MEM_TIMEOUT)
   ) u_wait_timer (
      .clk     (clk),
      .reset_n (reset_n),
      .clear   (wait_clr),
      .count   (wait_cnt),
      .expired (expired)
   );

   always_comb begin
      state_d       = state_q;
      op_d          = op_q;
      instret_d     = instret_q;
      imem_req      = 1'b0;
      dmem_req      = 1'b0;
      dmem_we       = 1'b0;
      ir_write      = 1'b0;
      pc_write      = 1'b0;
      pc_src        = 1'b0;
      alu_src_b     = 1'b0;
      alu_op        = ALU_ADD;
      reg_write     = 1'b0;
      mem_to_reg    = 1'b0;
      illegal_instr = 1'b0;
      bus_error     = 1'b0;

      case (state_q)
         S_FETCH: begin
            imem_req = 1'b1;
            if (imem_ready) begin
               ir_write = 1'b1;
               pc_write = 1'b1;
               state_d  = S_DECODE;
            end else if (expired) begin
               imem_req  = 1'b0;
               bus_error = 1'b1;
               state_d   = S_FETCH;
            end
         end
         S_DECODE: begin
            op_d = opcode;
            case (opcode)
               OP_R, OP_I, OP_LUI: state_d = S_EXECUTE;
               OP_LW, OP_SW:       state_d = S_ADDR;
               OP_BEQ:             state_d = S_BRANCH;
               default: begin
                  illegal_instr = 1'b1;
                  state_d       = S_FETCH;
               end
            endcase
         end
         S_EXECUTE: begin
            alu_op    = (op_q == OP_LUI) ? ALU_LUI : ALU_RI;
            alu_src_b = (op_q != OP_R);
            state_d   = S_ALU_WB;
         end
         S_ALU_WB: begin
            reg_write = 1'b1;
            instret_d = instret_q + 1'b1;
            state_d   = S_FETCH;
         end
         S_ADDR: begin
            alu_op    = ALU_ADD;
            alu_src_b = 1'b1;
            state_d   = (op_q == OP_SW) ? S_MEM_WR : S_MEM_RD;
         end
         S_MEM_RD: begin
            dmem_req = 1'b1;
            if (dmem_ready) begin
               state_d = S_MEM_WB;
            end else if (expired) begin
               dmem_req  = 1'b0;
               bus_error = 1'b1;
               state_d   = S_FETCH;
            end
         end
         S_MEM_WB: begin
            reg_write  = 1'b1;
            mem_to_reg = 1'b1;
            instret_d  = instret_q + 1'b1;
            state_d    = S_FETCH;
         end
         S_MEM_WR: begin
            dmem_req = 1'b1;
            dmem_we  = 1'b1;
            if (dmem_ready) begin
               instret_d = instret_q + 1'b1;
               state_d   = S_FETCH;
            end else if (expired) begin
               dmem_req  = 1'b0;
               dmem_we   = 1'b0;
               bus_error = 1'b1;
               state_d   = S_FETCH;
            end
         end
         S_BRANCH: begin
            alu_op    = ALU_BR;
            pc_src    = 1'b1;
            pc_write  = zero;
            instret_d = instret_q + 1'b1;
            state_d   = S_FETCH;
         end
         default: state_d = S_FETCH;
      endcase

      // Strobes are quiet for the whole time reset is held, not just after the edge.
      if (!reset_n) begin
         imem_req      = 1'b0;
         dmem_req      = 1'b0;
         dmem_we       = 1'b0;
         ir_write      = 1'b0;
         pc_write      = 1'b0;
         pc_src        = 1'b0;
         alu_src_b     = 1'b0;
         alu_op        = ALU_ADD;
         reg_write     = 1'b0;
         mem_to_reg    = 1'b0;
         illegal_instr = 1'b0;
         bus_error     = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_q   <= S_FETCH;
         op_q      <= '0;
         instret_q <= '0;
      end else begin
         state_q   <= state_d;
         op_q      <= op_d;
         instret_q <= instret_d;
      end
   end

   assign instret = instret_q;

endmodule
